cp0_unit: RTL
=============

Name: cp0_unit

Overview:
- Coprocessor 0 for the P7 pipeline, located at the M stage.
- Consumes the exception information carried by the E/M pipeline register: victim PC, exception code and branch-delay flag.
- Combines that with external hardware interrupt lines and produces the single request strobe that flushes and redirects every pipeline register.
- Holds SR, Cause, EPC and PRId; services mtc0/mfc0 and eret.

Parameters:
- PRID, 32'h2024_0707, constant value returned by reads of register 15.
- HW_INT_W, 6, number of hardware interrupt lines; maps to SR.IM/Cause.IP bits [15:10].

Ports:
- i_clk  input  1  clock
- i_reset  input  1  synchronous active-high reset
- i_en  input  1  mtc0 write enable (M stage)
- i_addr  input  5  CP0 register number for read/write
- i_wdata  input  32  mtc0 write data
- i_pc  input  32  PC of the M-stage instruction (victim PC)
- i_exc_code  input  5  exception code from M stage; 0 = none
- i_branch_delay  input  1  M-stage instruction sits in a delay slot
- i_eret  input  1  eret in M stage
- i_hw_int  input  HW_INT_W  external interrupt lines, level-sensitive
- o_req  output  1  exception/interrupt request to all pipeline registers and the NPC logic
- o_epc  output  32  current EPC, consumed by the NPC logic for eret
- o_rdata  output  32  mfc0 read data, combinational on i_addr

Behaviour:
- Reset is i_reset, synchronous, active-high; the clock is i_clk.
- Reset state: SR=0, Cause=0, EPC=0. While i_reset is high, o_req=0. With EPC=0, o_epc=0.
- SR (12) fields: IM=[15:10], EXL=[1], IE=[0]. All other bits read 0.
- Cause (13) fields: BD=[31], IP=[15:10], ExcCode=[6:2]. All other bits read 0.
- EPC (14): 32 bits, bits [1:0] forced to 0.
- PRId (15): PRID.
- Any other address reads 0.
- Two-state machine driven by SR.EXL:
  - NORMAL: EXL=0.
  - EXCEPTION: EXL=1.
- int_req = IE & ~EXL & |(IM & i_hw_int).
- exc_req = ~EXL & (i_exc_code != 0).
- o_req = (int_req | exc_req) & ~i_reset. It is combinational, so pipeline registers see it in the same cycle.
- On a clock edge with o_req=1 (NORMAL -> EXCEPTION):
  - EXL<=1.
  - BD<=i_branch_delay.
  - ExcCode<= int_req ? 0 : i_exc_code. An interrupt has priority over a simultaneous exception.
  - EPC<= i_branch_delay ? i_pc-4 : i_pc, computed modulo 2^32.
- eret (EXCEPTION -> NORMAL): on a clock edge with i_eret=1 and o_req=0, EXL<=0.
- mtc0, when i_en=1 and o_req=0:
  - addr 12 writes IM, EXL and IE.
  - addr 14 writes EPC with bits [1:0] forced to 0.
  - Writes to 13, 15 and all other addresses are ignored.
- Update priority per edge: reset > request > eret > mtc0.
  - eret and mtc0 are both ignored on a request edge.
  - mtc0 to SR on the same edge as eret: eret's EXL clear wins; IM and IE take the written values.
- Cause.IP <= i_hw_int on every edge, regardless of EXL or a request. It is cleared by reset.
- While in EXCEPTION, further exceptions and interrupts are masked: o_req stays 0 and the registers are not updated.
- The M-stage flush on a request is performed by the pipeline registers, not by this block.

Optional Feature:
- Macro: CP0_EPC_BYPASS_EN.
- Defined: when i_en=1 and i_addr=14 in the current cycle, o_epc=i_wdata with bits [1:0] forced to 0. An mtc0 EPC immediately followed by eret then returns correctly without a stall.
- Not defined: o_epc is always the registered EPC. Hazard logic must stall eret behind an in-flight mtc0 EPC.

Test Plan:
- Reset, then read addr 12/13/14/15 -> o_rdata = 0, 0, 0, 32'h2024_0707; o_req=0 with i_exc_code=5'd10 applied during reset.
- mtc0 SR=32'h0000_0401 and pulse i_hw_int=6'b000001 -> o_req=1 in the same cycle; next cycle EXL=1, ExcCode=0, EPC=i_pc (e.g. 32'h0000_3010); o_req then drops to 0 while i_hw_int is still high.
- Set i_exc_code=5'd4, i_branch_delay=1, i_pc=32'h0000_3024 -> o_req=1; Cause reads 32'h8000_0010; EPC=32'h0000_3020.
- Same cycle: interrupt enabled, i_hw_int[2]=1 and i_exc_code=5'd12 -> ExcCode=0; Cause.IP bit 12 set.
- In EXCEPTION, assert i_exc_code=5'd10 -> o_req=0 and EPC unchanged; then i_eret=1 -> EXL=0 next cycle, and o_req reasserts if the interrupt is still pending.
- mtc0 EPC=32'h0000_4003 with i_eret=1 in the same cycle -> with CP0_EPC_BYPASS_EN, o_epc=32'h0000_4000 that cycle; without it, o_epc shows the old EPC; EPC reads 32'h0000_4000 afterwards in both builds.

Source files
------------

// File: rtl/cp0_unit.sv
// rtl/cp0_unit.sv - P7 M-stage coprocessor 0 (SR/Cause/EPC/PRId, exception request); option CP0_EPC_BYPASS_EN
module cp0_unit #(
    parameter logic [31:0] PRID     = 32'h2024_0707,
    parameter int          HW_INT_W = 6
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_en,
    input  logic [4:0]          i_addr,
    input  logic [31:0]         i_wdata,
    input  logic [31:0]         i_pc,
    input  logic [4:0]          i_exc_code,
    input  logic                i_branch_delay,
    input  logic                i_eret,
    input  logic [HW_INT_W-1:0] i_hw_int,
    output logic                o_req,
    output logic [31:0]         o_epc,
    output logic [31:0]         o_rdata
);
    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;
    localparam logic [4:0] ADDR_PRID  = 5'd15;

    typedef enum logic {
        NORMAL    = 1'b0,
        EXCEPTION = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [HW_INT_W-1:0]   im_q, im_d;
    logic                  ie_q, ie_d;
    logic                  bd_q, bd_d;
    logic [HW_INT_W-1:0]   ip_q;
    logic [4:0]            exc_code_q, exc_code_d;
    logic [31:0]           epc_q, epc_d;

    logic                  exl;
    logic                  int_req;
    logic                  exc_req;
    logic                  wr_sr;
    logic                  wr_epc;
    logic                  unused_wdata;

    assign exl     = (state_q == EXCEPTION);
    assign int_req = ie_q & ~exl & (|(im_q & i_hw_int));
    assign exc_req = ~exl & (i_exc_code != 5'd0);
    assign o_req   = (int_req | exc_req) & ~i_reset;
    assign wr_sr   = i_en & (i_addr == ADDR_SR);
    assign wr_epc  = i_en & (i_addr == ADDR_EPC);

    // Only a subset of the write bus is architecturally meaningful.
    assign unused_wdata = ^i_wdata;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= NORMAL;
            im_q       <= '0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ip_q       <= '0;
            exc_code_q <= 5'd0;
            epc_q      <= 32'd0;
        end else begin
            state_q    <= state_d;
            im_q       <= im_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ip_q       <= i_hw_int;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        im_d       = im_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;
        if (o_req) begin
            state_d    = EXCEPTION;
            bd_d       = i_branch_delay;
            exc_code_d = int_req ? 5'd0 : i_exc_code;
            epc_d      = (i_branch_delay ? (i_pc - 32'd4) : i_pc) & 32'hFFFF_FFFC;
        end else begin
            if (wr_sr) begin
                im_d    = i_wdata[10 +: HW_INT_W];
                ie_d    = i_wdata[0];
                state_d = i_wdata[1] ? EXCEPTION : NORMAL;
            end
            if (wr_epc) begin
                epc_d = {i_wdata[31:2], 2'b00};
            end
            // eret is applied after mtc0 so its EXL clear overrides a same-edge SR write.
            if (i_eret) begin
                state_d = NORMAL;
            end
        end
    end

    always_comb begin
        o_rdata = 32'd0;
        case (i_addr)
            ADDR_SR: begin
                o_rdata[10 +: HW_INT_W] = im_q;
                o_rdata[1]              = exl;
                o_rdata[0]              = ie_q;
            end
            ADDR_CAUSE: begin
                o_rdata[31]             = bd_q;
                o_rdata[10 +: HW_INT_W] = ip_q;
                o_rdata[6:2]            = exc_code_q;
            end
            ADDR_EPC:  o_rdata = epc_q;
            ADDR_PRID: o_rdata = PRID;
            default:   o_rdata = 32'd0;
        endcase
    end

`ifdef CP0_EPC_BYPASS_EN
    assign o_epc = wr_epc ? {i_wdata[31:2], 2'b00} : epc_q;
`else
    assign o_epc = epc_q;
`endif

endmodule
